// File: rtl/cp_strip_ctrl_pkg.sv
// cp_strip_ctrl_pkg: shared OFDM receive definitions
//   state_e          sequencer states (IDLE, CP, DATA, DONE)
//   *_DEF            default symbol geometry and sample width
//   cnt_w()          counter width for a modulus, never below 1 bit
package cp_strip_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CP, DATA, DONE} state_e;
    localparam int FFT_LEN_DEF    = 64;
    localparam int CP_LEN_DEF     = 16;
    localparam int DATA_WIDTH_DEF = 13;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cp_strip_ctrl_sym_counter.sv
// cp_strip_ctrl_sym_counter: loadable up-counter with enable and terminal-count flag
//   clk, rst     clock, asynchronous active-high reset
//   ld_i         load ld_val_i (wins over en_i)
//   ld_val_i     load value
//   en_i         count up by one
//   term_i       terminal value compared against the count
//   cnt_o        current count
//   tc_o         count equals term_i
module cp_strip_ctrl_sym_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = ld_i ? ld_val_i : en_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == term_i;
endmodule

// File: rtl/cp_strip_ctrl.sv
// cp_strip_ctrl: OFDM receive sequencer, strips the cyclic prefix and frames symbols
//   clk, rst       clock, asynchronous active-high reset
//   start_i        begins a frame (IDLE only)
//   abort_i        synchronous return to IDLE
//   in_valid_i     upstream sample valid
//   in_data_i      upstream sample
//   in_ready_o     high in CP and DATA
//   out_valid_o    forwarded data sample valid (latency 1)
//   out_data_o     forwarded data sample, holds otherwise
//   sr_shift_o     delay-line shift enable, equals out_valid_o
//   sym_start_o    first forwarded sample of each symbol
//   frame_done_o   pulse after the last data sample of the frame
//   busy_o         sequencer not idle
//   out_sym_idx_o  symbol index of each forwarded sample (CP_STRIP_SYM_IDX_EN only)
module cp_strip_ctrl
    import cp_strip_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int FFT_LEN       = FFT_LEN_DEF,
    parameter int CP_LEN        = CP_LEN_DEF,
    parameter int SYM_PER_FRAME = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  sr_shift_o,
    output logic                  sym_start_o,
    output logic                  frame_done_o,
    output logic                  busy_o
`ifdef CP_STRIP_SYM_IDX_EN
    ,
    output logic [cnt_w(SYM_PER_FRAME)-1:0] out_sym_idx_o
`endif
);
    localparam int SW = cnt_w(FFT_LEN);
    localparam int YW = cnt_w(SYM_PER_FRAME);

    state_e          state_q, state_d;
    logic [SW-1:0]   samp_cnt, samp_term;
    logic [YW-1:0]   sym_cnt;
    logic            samp_tc, sym_tc, acc;
    logic            out_valid_q, out_valid_d;
    logic            sym_start_q, sym_start_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    assign in_ready_o = state_q == CP || state_q == DATA;
    assign acc        = in_valid_i && in_ready_o;
    // One sample counter serves both phases; only its terminal value changes.
    assign samp_term  = state_q == CP ? SW'(CP_LEN - 1) : SW'(FFT_LEN - 1);

    cp_strip_ctrl_sym_counter #(.W(SW)) u_samp_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (abort_i || !in_ready_o || (acc && samp_tc)),
        .ld_val_i ('0),
        .en_i     (acc),
        .term_i   (samp_term),
        .cnt_o    (samp_cnt),
        .tc_o     (samp_tc)
    );

    cp_strip_ctrl_sym_counter #(.W(YW)) u_sym_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (abort_i || state_q == IDLE),
        .ld_val_i ('0),
        .en_i     (acc && state_q == DATA && samp_tc && !sym_tc),
        .term_i   (YW'(SYM_PER_FRAME - 1)),
        .cnt_o    (sym_cnt),
        .tc_o     (sym_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CP;
            CP:      if (acc && samp_tc) state_d = DATA;
            DATA:    if (acc && samp_tc) state_d = sym_tc ? DONE : CP;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
        out_valid_d  = acc && state_q == DATA && !abort_i;
        sym_start_d  = out_valid_d && samp_cnt == '0;
        frame_done_d = state_q == DONE && !abort_i;
        out_data_d   = out_valid_d ? in_data_i : out_data_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            sym_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            sym_start_q  <= sym_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= state_d != IDLE;
            out_data_q   <= out_data_d;
        end

`ifdef CP_STRIP_SYM_IDX_EN
    logic [YW-1:0] sym_idx_q, sym_idx_d;
    assign sym_idx_d = out_valid_d ? sym_cnt : sym_idx_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sym_idx_q <= '0;
        else     sym_idx_q <= sym_idx_d;
    assign out_sym_idx_o = sym_idx_q;
`endif

    assign out_valid_o  = out_valid_q;
    assign sr_shift_o   = out_valid_q;
    assign out_data_o   = out_data_q;
    assign sym_start_o  = sym_start_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_cp_strip_ctrl.sv
// tb_cp_strip_ctrl: self-checking bench for cp_strip_ctrl (default and small-geometry instances)
module tb_cp_strip_ctrl;
    localparam int DW = 13, CPA = 16, FFTA = 64, SYMA = 2, LA = CPA + FFTA, TOTA = LA * SYMA;

    logic clk = 1'b0, rst = 1'b1;
    logic a_start = 1'b0, a_abort = 1'b0, a_iv = 1'b0;
    logic [DW-1:0] a_id = '0, a_od;
    logic a_rdy, a_ov, a_ss, a_sst, a_fd, a_busy;
    logic b_start = 1'b0, b_abort = 1'b0, b_iv = 1'b0;
    logic [DW-1:0] b_id = '0, b_od;
    logic b_rdy, b_ov, b_ss, b_sst, b_fd, b_busy;
`ifdef CP_STRIP_SYM_IDX_EN
    logic [0:0] a_idx, b_idx;
`endif

    int n_cmp = 0, n_err = 0;
    int ph = 0, n = 0, last_idx = 0;
    logic [DW-1:0] last_d = '0;
    int cnt_ov, cnt_ss, cnt_fd;

    typedef struct {
        logic st, v;
        logic [DW-1:0] d;
        logic ov;
        logic [DW-1:0] od;
        logic ss, fd, busy;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    cp_strip_ctrl #(.DATA_WIDTH(DW), .FFT_LEN(FFTA), .CP_LEN(CPA), .SYM_PER_FRAME(SYMA)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort), .in_valid_i(a_iv),
        .in_data_i(a_id), .in_ready_o(a_rdy), .out_valid_o(a_ov), .out_data_o(a_od),
        .sr_shift_o(a_ss), .sym_start_o(a_sst), .frame_done_o(a_fd), .busy_o(a_busy)
`ifdef CP_STRIP_SYM_IDX_EN
        , .out_sym_idx_o(a_idx)
`endif
    );

    cp_strip_ctrl #(.DATA_WIDTH(DW), .FFT_LEN(4), .CP_LEN(1), .SYM_PER_FRAME(1)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort), .in_valid_i(b_iv),
        .in_data_i(b_id), .in_ready_o(b_rdy), .out_valid_o(b_ov), .out_data_o(b_od),
        .sr_shift_o(b_ss), .sym_start_o(b_sst), .frame_done_o(b_fd), .busy_o(b_busy)
`ifdef CP_STRIP_SYM_IDX_EN
        , .out_sym_idx_o(b_idx)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int st, v, d, ov, od, ss, fd, busy);
        vec_t r;
        r.st = st[0]; r.v = v[0]; r.d = DW'(d); r.ov = ov[0];
        r.od = DW'(od); r.ss = ss[0]; r.fd = fd[0]; r.busy = busy[0];
        return r;
    endfunction

    // Reference for instance A: a frame is TOTA accepted samples; accepted sample k is
    // data iff k mod LA >= CPA, and opens a symbol iff k mod LA == CPA.
    task automatic a_cycle(input bit v, input bit st, input bit ab);
        bit rdy, acc, ev, es, efd;
        int pos;
        a_iv = v; a_start = st; a_abort = ab; a_id = DW'(n);
        rdy = ph == 1;
        #1 check("a in_ready", a_rdy, rdy);
        acc = v && rdy;
        pos = n % LA;
        ev  = acc && !ab && pos >= CPA;
        es  = ev && pos == CPA;
        efd = ph == 2 && !ab;
        if (ev) begin last_d = DW'(n); last_idx = n / LA; end
        if (ab) begin ph = 0; n = 0; end
        else if (ph == 0) begin if (st) begin ph = 1; n = 0; end end
        else if (ph == 1) begin if (acc) begin n++; if (n == TOTA) ph = 2; end end
        else ph = 0;
        @(posedge clk); #1;
        check("a out_valid", a_ov, ev);
        check("a sr_shift", a_ss, ev);
        check("a sym_start", a_sst, es);
        check("a frame_done", a_fd, efd);
        check("a busy", a_busy, ph != 0);
        check("a out_data", a_od, last_d);
`ifdef CP_STRIP_SYM_IDX_EN
        check("a out_sym_idx", a_idx, last_idx);
`endif
        cnt_ov += a_ov; cnt_ss += a_sst; cnt_fd += a_fd;
    endtask

    task automatic run_frame(input int pct, input bit rs, input string tag);
        int cyc = 0;
        cnt_ov = 0; cnt_ss = 0; cnt_fd = 0;
        a_cycle(0, 1, 0);
        while (ph != 0 && cyc < 4000) begin
            a_cycle($urandom_range(99) < pct, rs && $urandom_range(7) == 0, 0);
            cyc++;
        end
        n_cmp++;
        if (ph != 0) begin
            n_err++;
            $display("FAIL %s frame_budget: still running after %0d cycles", tag, cyc);
        end
        check({tag, " out_valid_count"}, cnt_ov, TOTA - SYMA * CPA);
        check({tag, " sym_start_count"}, cnt_ss, SYMA);
        check({tag, " frame_done_count"}, cnt_fd, 1);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0,  0, 0,  0, 0, 1);
        tbl[1]  = mk(0, 1, 0,  0, 0,  0, 0, 1);
        tbl[2]  = mk(0, 1, 1,  1, 1,  1, 0, 1);
        tbl[3]  = mk(0, 0, 9,  0, 1,  0, 0, 1);
        tbl[4]  = mk(0, 1, 2,  1, 2,  0, 0, 1);
        tbl[5]  = mk(0, 1, 3,  1, 3,  0, 0, 1);
        tbl[6]  = mk(0, 1, 4,  1, 4,  0, 0, 1);
        tbl[7]  = mk(1, 1, 5,  0, 4,  0, 1, 0);
        tbl[8]  = mk(1, 0, 0,  0, 4,  0, 0, 1);
        tbl[9]  = mk(0, 1, 10, 0, 4,  0, 0, 1);
        tbl[10] = mk(0, 1, 11, 1, 11, 1, 0, 1);
        tbl[11] = mk(0, 1, 12, 1, 12, 0, 0, 1);
        tbl[12] = mk(0, 1, 13, 1, 13, 0, 0, 1);
        tbl[13] = mk(0, 1, 14, 1, 14, 0, 0, 1);
        tbl[14] = mk(0, 0, 0,  0, 14, 0, 1, 0);
        tbl[15] = mk(0, 0, 0,  0, 14, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", a_ov, 0);
        check("rst sr_shift", a_ss, 0);
        check("rst sym_start", a_sst, 0);
        check("rst frame_done", a_fd, 0);
        check("rst busy", a_busy, 0);
        check("rst out_data", a_od, 0);
        check("rst in_ready", a_rdy, 0);
        check("rst b busy", b_busy, 0);
        @(negedge clk) rst = 1'b0;

        repeat (3) a_cycle(1, 0, 0);
        run_frame(100, 0, "continuous");
        run_frame(50, 1, "gaps");

        a_cycle(0, 1, 0);
        repeat (LA + CPA + 5) a_cycle(1, 0, 0);
        a_cycle(1, 0, 1);
        repeat (3) a_cycle(1, 0, 0);
        run_frame(100, 1, "post_abort");

        a_cycle(0, 1, 0);
        repeat (LA + CPA + 3) a_cycle(1, 0, 0);
        check("pre_rst out_valid", a_ov, 1);
        #2 rst = 1'b1;
        #1;
        check("async out_valid", a_ov, 0);
        check("async sr_shift", a_ss, 0);
        check("async busy", a_busy, 0);
        check("async out_data", a_od, 0);
        check("async in_ready", a_rdy, 0);
        check("async sym_start", a_sst, 0);
        check("async frame_done", a_fd, 0);
`ifdef CP_STRIP_SYM_IDX_EN
        check("async out_sym_idx", a_idx, 0);
`endif
        ph = 0; n = 0; last_d = '0; last_idx = 0;
        a_start = 1'b0; a_iv = 1'b0; a_abort = 1'b0;
        @(negedge clk) rst = 1'b0;
        run_frame(70, 0, "post_reset");

        for (int i = 0; i < 16; i++) begin
            b_start = tbl[i].st; b_iv = tbl[i].v; b_id = tbl[i].d;
            @(posedge clk); #1;
            check($sformatf("b[%0d] out_valid", i), b_ov, tbl[i].ov);
            check($sformatf("b[%0d] sr_shift", i), b_ss, tbl[i].ov);
            check($sformatf("b[%0d] out_data", i), b_od, tbl[i].od);
            check($sformatf("b[%0d] sym_start", i), b_sst, tbl[i].ss);
            check($sformatf("b[%0d] frame_done", i), b_fd, tbl[i].fd);
            check($sformatf("b[%0d] busy", i), b_busy, tbl[i].busy);
`ifdef CP_STRIP_SYM_IDX_EN
            check($sformatf("b[%0d] out_sym_idx", i), b_idx, 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cp_strip_ctrl.md
Name: cp_strip_ctrl

Overview:
- Per-antenna OFDM receive sequencer. It frames the incoming time-domain sample stream into symbols of CP_LEN + FFT_LEN samples and discards the cyclic prefix.
- It forwards the FFT_LEN data samples with a registered valid.
- It drives the shift-enable of the downstream 64-deep symbol delay line, so only data samples are shifted in.
- It reports symbol and frame boundaries to the FFT and channel-estimation control.

Parameters:
DATA_WIDTH, 13, sample width (I or Q packed word as used by the delay line)
FFT_LEN, 64, data samples per symbol; must equal the delay-line DEPTH
CP_LEN, 16, cyclic-prefix samples per symbol; legal range 1..FFT_LEN
SYM_PER_FRAME, 8, OFDM symbols per frame; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a frame (honoured only in IDLE)
abort  in  1  synchronous; forces IDLE on the next edge, overrides everything except rst
in_valid  in  1  upstream sample valid
in_data  in  DATA_WIDTH  upstream sample
in_ready  out  1  combinational; 1 in CP and DATA states, else 0
out_valid  out  1  registered; data sample forwarded
out_data  out  DATA_WIDTH  registered forwarded sample
sr_shift  out  1  registered; drives the delay-line valid, identical to out_valid
sym_start  out  1  registered pulse coincident with the first out_valid of each symbol
frame_done  out  1  registered single-cycle pulse after the last data sample of the frame
busy  out  1  registered; 1 in any state other than IDLE

Behaviour:
- Reset: state=IDLE; all counters 0. out_valid, sr_shift, sym_start, frame_done and busy are 0; out_data is 0.
- Accept: a sample is accepted on a cycle where in_valid && in_ready. Non-accepted cycles leave the counters unchanged. Gaps in in_valid are allowed at any point.
- State machine:
  - IDLE: on start, go to CP with samp_cnt=0 and sym_cnt=0. in_valid is ignored in IDLE.
  - CP: each accept increments samp_cnt. The sample is dropped (no out_valid). Accepting with samp_cnt==CP_LEN-1 moves to DATA with samp_cnt=0.
  - DATA: each accept is registered to out_data, and out_valid=sr_shift=1 on the next cycle (latency 1). sym_start=1 with the output of the accept at samp_cnt==0. Accepting with samp_cnt==FFT_LEN-1 has two outcomes:
    - sym_cnt==SYM_PER_FRAME-1: go to DONE.
    - otherwise: sym_cnt+1 and go to CP with samp_cnt=0.
  - DONE: lasts one cycle. frame_done=1 in the following cycle, then go to IDLE.
- A start in the DONE cycle is ignored. Back-to-back frames need start in IDLE; the earliest is the cycle frame_done is high.
- start outside IDLE is ignored.
- abort: returns to IDLE and clears counters on the next edge. The out_valid for a sample accepted in the abort cycle is suppressed.
- Output hold: out_data holds its last value when out_valid=0. out_valid, sr_shift, sym_start and frame_done are 0 on every cycle not described above.
- Widths:
  - samp_cnt is $clog2(FFT_LEN) bits; CP_LEN-1 is compared at the same width.
  - sym_cnt is max(1, $clog2(SYM_PER_FRAME)) bits.
  - No wrap-around beyond the terminal compares.
- busy is registered from the next-state.

Optional Feature:
- Macro: CP_STRIP_SYM_IDX_EN.
- Defined: adds output out_sym_idx, width max(1,$clog2(SYM_PER_FRAME)). It is registered alongside out_data, carries sym_cnt for each forwarded sample, holds when out_valid=0, and resets to 0.
- Undefined: the port and its register are absent, and behaviour is otherwise identical.

Decomposition:
- Shared OFDM package holds:
  - state enum (IDLE, CP, DATA, DONE);
  - default constants FFT_LEN=64, CP_LEN=16, DATA_WIDTH=13;
  - a clog2-based width function for the counters.
- One natural sub-module: sym_counter. It is a loadable up-counter with enable and terminal-count flag, instantiated twice (samples, symbols).

Test Plan (defaults unless noted, SYM_PER_FRAME=2):
- Reset mid-frame, asserted during DATA: all outputs drop to 0 asynchronously; busy=0; a following start gives a clean frame.
- Continuous in_valid=1 with in_data=0,1,2…: start, then samples 0..15 dropped and 16..79 output one cycle after accept. sym_start comes with data 16 and with data 96, and 128 out_valid total. frame_done pulses once, the cycle after data 159 is output.
- Random in_valid gaps (50%), same data ramp: same 128 outputs in order; no output during gaps; counters frozen.
- start pulsed in CP and DATA: ignored, frame length unchanged. abort in DATA with in_valid=1: no further out_valid; IDLE and busy=0 after one edge.
- CP_LEN=1, FFT_LEN=4, SYM_PER_FRAME=1: ramp 0..4 gives outputs 1,2,3,4 and frame_done; a second start the cycle frame_done is high runs a full frame.
- With CP_STRIP_SYM_IDX_EN: out_sym_idx=0 for the first 64 outputs and 1 for the next 64.
